vga_digit_render: RTL

- Pixel-pipeline stage directly downstream of the per-digit glyph ROMs (16x16, row-addressed, bit 0 = leftmost pixel).
- Takes VGA raster coordinates, generates the glyph row address for four on-screen digit slots and samples the returned row bits.
- Slots: first operand, second operand, result tens, result units.
- Drives the Basys3 12-bit VGA colour outputs and the delay-matched sync signals.
- Includes a frame-counted blink for the result slots.

---
 rtl/vga_digit_render.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vga_digit_render.sv
// rtl/vga_digit_render.sv - two-stage glyph sampling and colour output for four digit slots
module vga_digit_render #(
   parameter int          X_L          = 256,
   parameter int          X_R          = 320,
   parameter int          Y_T          = 160,
   parameter int          Y_B          = 256,
   parameter int          SCALE_SH     = 1,
   parameter logic [11:0] FG_OP        = 12'hFFF,
   parameter logic [11:0] FG_RES       = 12'h0F0,
   parameter int          BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  h_cnt,
   input  logic [9:0]  v_cnt,
   input  logic        video_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        show_op,
   input  logic        show_res,
   input  logic        blink_en,
   output logic [3:0]  addr_fir,
   output logic [3:0]  addr_sec,
   output logic [3:0]  addr_disp_u,
   output logic [3:0]  addr_disp_d,
   input  logic [15:0] Char_fir,
   input  logic [15:0] Char_sec,
   input  logic [15:0] Char_disp_u,
   input  logic [15:0] Char_disp_d,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        hsync,
   output logic        vsync
);

   localparam logic [9:0] SLOT_SZ = 10'(16 << SCALE_SH);
   localparam int         CW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

   // slot index: 0 = fir, 1 = sec, 2 = disp_d, 3 = disp_u
   logic [3:0][9:0] dx, dy;
   logic [3:0]      hit_c;
   logic [3:0][3:0] col_c, addr_c;

   logic [3:0]      hit_q;
   logic [3:0][3:0] col_q, addr_q;
   logic            von_d1, hs_d1, vs_d1;

   logic [3:0]      pix_bit;
   logic            pix_op, pix_res;
   logic [11:0]     colour_c, colour_q;

   logic [CW-1:0]   frame_cnt;
   logic            blink_phase;
   logic            vs_fall;

   // slot hit test: unsigned wrap makes coordinates left of / above the origin miss
   always_comb begin
      dx[0] = h_cnt - 10'(X_L);
      dy[0] = v_cnt - 10'(Y_T);
      dx[1] = h_cnt - 10'(X_R);
      dy[1] = v_cnt - 10'(Y_T);
      dx[2] = h_cnt - 10'(X_L);
      dy[2] = v_cnt - 10'(Y_B);
      dx[3] = h_cnt - 10'(X_R);
      dy[3] = v_cnt - 10'(Y_B);
      hit_c  = '0;
      col_c  = '0;
      addr_c = '0;
      for (int s = 0; s < 4; s++) begin
         hit_c[s]  = (dx[s] < SLOT_SZ) && (dy[s] < SLOT_SZ);
         col_c[s]  = 4'(dx[s] >> SCALE_SH);
         addr_c[s] = hit_c[s] ? 4'(dy[s] >> SCALE_SH) : 4'd0;
      end
   end

   // stage 1: ROM row addresses plus the per-slot column/hit and sync delay line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         hit_q  <= '0;
         col_q  <= '0;
         von_d1 <= 1'b0;
         hs_d1  <= 1'b1;
         vs_d1  <= 1'b1;
      end else begin
         addr_q <= addr_c;
         hit_q  <= hit_c;
         col_q  <= col_c;
         von_d1 <= video_on;
         hs_d1  <= hsync_in;
         vs_d1  <= vsync_in;
      end
   end

   assign addr_fir    = addr_q[0];
   assign addr_sec    = addr_q[1];
   assign addr_disp_d = addr_q[2];
   assign addr_disp_u = addr_q[3];

   // glyph bit select on the returned ROM rows; operand colour wins any overlap
   always_comb begin
      pix_bit[0] = hit_q[0] & Char_fir[col_q[0]];
      pix_bit[1] = hit_q[1] & Char_sec[col_q[1]];
      pix_bit[2] = hit_q[2] & Char_disp_d[col_q[2]];
      pix_bit[3] = hit_q[3] & Char_disp_u[col_q[3]];
      pix_op     = show_op & (pix_bit[0] | pix_bit[1]);
      pix_res    = show_res & ~(blink_en & blink_phase) & (pix_bit[2] | pix_bit[3]);
      colour_c   = 12'h000;
      if (von_d1) begin
         if (pix_op)
            colour_c = FG_OP;
         else if (pix_res)
            colour_c = FG_RES;
      end
   end

   // stage 2: colour and syncs leave together, two clocks after the raster inputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         colour_q <= 12'h000;
         hsync    <= 1'b1;
         vsync    <= 1'b1;
      end else begin
         colour_q <= colour_c;
         hsync    <= hs_d1;
         vsync    <= vs_d1;
      end
   end

   assign {vga_r, vga_g, vga_b} = colour_q;

   assign vs_fall = vs_d1 & ~vsync_in;

   // frame counter toggles the blink phase; disabling blink restarts from the visible phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (!blink_en) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (vs_fall) begin
         if (frame_cnt == CNT_LAST) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

endmodule
